// File: rtl/rs_framer_pkg.sv
// Shared types and helpers for the RS message framer.
// Holds the framer state encoding and the symbol-counter width helper.
package rs_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  // Counter width for indices 0..n-1; never narrower than one bit.
  function automatic int sym_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_msg_framer_chk.sv
// Protocol properties for the framer's FIFO read port and output handshake.
// Purely observational; has no outputs and drives nothing.
module rs_msg_framer_chk #(
  parameter int width_p = 8
) (
  input logic               clk,
  input logic               rst_n,
  input logic               fifo_rd_req,
  input logic               fifo_empty,
  input logic               out_val,
  input logic               out_rdy,
  input logic [width_p-1:0] out_data,
  input logic               out_sop,
  input logic               out_eop
);

  // A pop must never be requested from an empty FIFO.
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_req && fifo_empty));

  // A stalled beat keeps its payload and markers until it is accepted.
  a_hold_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (out_val && !out_rdy) |=> (out_val && $stable(out_data) && $stable(out_sop) && $stable(out_eop)));

endmodule

// File: rtl/rs_msg_framer.sv
// Frames FIFO symbols into fixed-length messages for the RS encoder, with
// zero-padding flush, sop/eop markers and a completed-message counter.
module rs_msg_framer
  import rs_framer_pkg::*;
#(
  parameter int width_p   = 8,
  parameter int msg_len_p = 223,
  parameter int cnt_w_p   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fifo_rd_req,
  input  logic [width_p-1:0] fifo_rd_data,
  input  logic               fifo_empty,
  input  logic               flush,
  output logic               out_val,
  output logic [width_p-1:0] out_data,
  output logic               out_sop,
  output logic               out_eop,
  input  logic               out_rdy,
  output logic [cnt_w_p-1:0] msg_count,
  output logic               busy
);

  localparam int              SC_W     = sym_cnt_w(msg_len_p);
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'(msg_len_p - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SC_W-1:0]     r_sym_cnt;
  logic [SC_W-1:0]     w_sym_cnt_nxt;
  logic                r_flush_pend;
  logic                w_flush_pend_nxt;

  logic                r_out_val;
  logic [width_p-1:0]  r_out_data;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [cnt_w_p-1:0]  r_msg_count;
  logic                r_busy;

  logic                w_load;
  logic                w_pop;
  logic                w_pad_load;
  logic                w_emit;
  logic                w_first;
  logic                w_last;
  logic                w_flush_eff;
  logic                w_out_val_nxt;

  // rst_n gates the pop so the FIFO sees no request while the framer is held in reset.
  assign w_load        = !r_out_val || out_rdy;
  assign w_pop         = rst_n && w_load && !fifo_empty && (r_state != ST_PAD);
  assign w_pad_load    = w_load && (r_state == ST_PAD);
  assign w_emit        = w_pop || w_pad_load;
  assign w_first       = (r_sym_cnt == '0);
  assign w_last        = (r_sym_cnt == LAST_IDX);
  assign w_flush_eff   = flush || r_flush_pend;
  assign w_out_val_nxt = w_load ? w_emit : r_out_val;

  // Next-state, symbol index and pending-flush logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    if (w_emit) begin
      w_sym_cnt_nxt = w_last ? '0 : r_sym_cnt + SC_W'(1);
    end else begin
      w_sym_cnt_nxt = r_sym_cnt;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_nxt = ST_MSG;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MSG: begin
        if (w_pop && w_last) begin
          w_state_nxt      = ST_IDLE;
          w_flush_pend_nxt = 1'b0;
        end else if (w_load && w_flush_eff) begin
          // Any pop in this cycle has already been taken; the rest is zero fill.
          w_state_nxt      = ST_PAD;
          w_flush_pend_nxt = 1'b1;
        end else if (flush) begin
          w_flush_pend_nxt = 1'b1;
        end else begin
          w_flush_pend_nxt = r_flush_pend;
        end
      end
      ST_PAD: begin
        if (w_pad_load && w_last) begin
          w_state_nxt      = ST_IDLE;
          w_flush_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_PAD;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_sym_cnt_nxt    = '0;
        w_flush_pend_nxt = 1'b0;
      end
    endcase
  end

  // Framer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sym_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sym_cnt    <= w_sym_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // Output beat register, message counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_val   <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_msg_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_out_val <= w_out_val_nxt;
      if (w_emit) begin
        r_out_data <= w_pop ? fifo_rd_data : '0;
        r_out_sop  <= w_first;
        r_out_eop  <= w_last;
      end
      if (r_out_val && out_rdy && r_out_eop) begin
        r_msg_count <= r_msg_count + cnt_w_p'(1);
      end
      r_busy <= (w_state_nxt != ST_IDLE) || w_out_val_nxt;
    end
  end

  assign fifo_rd_req = w_pop;
  assign out_val     = r_out_val;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign msg_count   = r_msg_count;
  assign busy        = r_busy;

  rs_msg_framer_chk #(
    .width_p (width_p)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_req (fifo_rd_req),
    .fifo_empty  (fifo_empty),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop)
  );

endmodule

// File: tb/tb_rs_msg_framer.sv
// Bench for rs_msg_framer (K=4): directed scenarios plus random traffic,
// checked against a message-level reference model and an in-order stream check.
module tb_rs_msg_framer;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_req;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        flush = 1'b0;
  logic        out_val;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_rdy = 1'b0;
  logic [15:0] msg_count;
  logic        busy;

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int acc0;

  // Reference model: one expected output register plus message position.
  logic [7:0]  fifo_q[$];
  logic [7:0]  pushed_q[$];
  bit          m_val, m_sop, m_eop, m_fpend;
  logic [7:0]  m_data;
  int          m_pos, m_pad;
  logic [15:0] m_count;

  rs_msg_framer #(.width_p(8), .msg_len_p(L), .cnt_w_p(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .flush(flush), .out_val(out_val), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_rdy(out_rdy), .msg_count(msg_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_sop = 0; m_eop = 0; m_fpend = 0; m_data = 8'h00;
    m_pos = 0; m_pad = 0; m_count = 16'h0000;
    fifo_q.delete();
    pushed_q.delete();
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + 8'(i));
      pushed_q.push_back(first + 8'(i));
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model.
  task automatic cycle(input bit do_push, input logic [7:0] pv, input bit rdy, input bit fl);
    bit load, exp_req;
    int was_pos;
    @(negedge clk);
    if (do_push) begin
      fifo_q.push_back(pv);
      pushed_q.push_back(pv);
    end
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? 8'h00 : fifo_q[0];
    out_rdy      = rdy;
    flush        = fl;
    #1;
    load    = !m_val || rdy;
    exp_req = load && !fifo_empty && (m_pad == 0);
    chk("rd_req", 32'(fifo_rd_req), 32'(exp_req));
    chk("out_val", 32'(out_val), 32'(m_val));
    if (m_val) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_sop", 32'(out_sop), 32'(m_sop));
      chk("out_eop", 32'(out_eop), 32'(m_eop));
    end
    chk("msg_count", 32'(msg_count), 32'(m_count));
    chk("busy", 32'(busy), 32'(m_val || (m_pos != 0)));
    if (out_val && rdy) begin
      n_acc++;
      if (out_data != 8'h00) begin
        if (pushed_q.size() == 0) chk("stream_extra", 32'(out_data), 32'h0);
        else chk("stream_order", 32'(out_data), 32'(pushed_q.pop_front()));
      end
    end
    if (m_val && rdy && m_eop) m_count = m_count + 16'd1;
    if (load) begin
      if (m_pad > 0) begin
        m_data = 8'h00; m_sop = (m_pos == 0); m_eop = (m_pos == L - 1);
        m_pos = (m_pos + 1) % L; m_pad--; m_val = 1;
      end else begin
        was_pos = m_pos;
        if (!fifo_empty) begin
          m_data = fifo_q[0]; m_sop = (m_pos == 0); m_eop = (m_pos == L - 1);
          m_pos = (m_pos + 1) % L; m_val = 1;
        end else begin
          m_val = 0;
        end
        if ((fl || m_fpend) && was_pos != 0 && m_pos != 0) m_pad = L - m_pos;
        m_fpend = 0;
      end
    end else if (fl && m_pad == 0 && m_pos != 0) begin
      m_fpend = 1;
    end
    if (fifo_rd_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    model_reset();
    #7;
    chk("rst_val", 32'(out_val), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_count", 32'(msg_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(fifo_rd_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back burst of two messages.
    acc0 = n_acc;
    preload(8'h11, 8);
    run(10, 1'b1);
    chk("burst_beats", 32'(n_acc - acc0), 32'd8);
    chk("burst_count", 32'(msg_count), 32'd2);

    // Partial message finished by flush; FIFO refill during padding.
    preload(8'hA1, 2);
    run(2, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 8'hB1, 1'b1, 1'b0);
    run(4, 1'b1);
    chk("pad_count", 32'(msg_count), 32'd3);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    run(5, 1'b1);
    chk("pad2_count", 32'(msg_count), 32'd4);

    // Ready toggling 1,0,0,1 against a full FIFO.
    acc0 = n_acc;
    preload(8'h31, 12);
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    chk("stall_beats", 32'(n_acc - acc0), 32'd12);
    chk("stall_count", 32'(msg_count), 32'd7);

    // FIFO runs dry mid-message then resumes.
    preload(8'h21, 2);
    run(7, 1'b1);
    cycle(1'b1, 8'h23, 1'b1, 1'b0);
    cycle(1'b1, 8'h24, 1'b1, 1'b0);
    run(3, 1'b1);
    chk("gap_count", 32'(msg_count), 32'd8);

    // Flush while idle, then flush coincident with the eop pop.
    acc0 = n_acc;
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    run(3, 1'b1);
    chk("idle_flush_beats", 32'(n_acc - acc0), 32'd0);
    chk("idle_flush_count", 32'(msg_count), 32'd8);
    preload(8'h41, 4);
    run(3, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    run(6, 1'b1);
    chk("eop_flush_beats", 32'(n_acc - acc0), 32'd4);
    chk("eop_flush_count", 32'(msg_count), 32'd9);

    // Random traffic, then drain and close any partial message.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) < 55, 8'($urandom_range(1, 255)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    run(60, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    run(10, 1'b1);
    chk("drain_fifo", 32'(fifo_q.size()), 32'd0);
    chk("drain_stream", 32'(pushed_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'h0);

    // Asynchronous reset between clock edges, mid-message.
    preload(8'h51, 3);
    run(2, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_val", 32'(out_val), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    chk("arst_sop", 32'(out_sop), 32'h0);
    chk("arst_eop", 32'(out_eop), 32'h0);
    chk("arst_count", 32'(msg_count), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_req", 32'(fifo_rd_req), 32'h0);
    model_reset();
    fifo_empty = 1'b1;
    fifo_rd_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_count", 32'(msg_count), 32'h0);
    preload(8'h61, 4);
    run(7, 1'b1);
    chk("post_rst_msgs", 32'(msg_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
